// File: rtl/fifo_drain_serializer.sv
// Reader side of the encoder output FIFO: pops bytes, serializes them over a
// valid/ready bit stream with a one-byte prefetch, and tracks frame boundaries.
module fifo_drain_serializer #(
    parameter int DATA_W      = 8,
    parameter int FRAME_BYTES = 4,
    parameter int CNT_W       = 8,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic [CNT_W-1:0]  byte_count,
    output logic              frame_done,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              bit_valid_q, bit_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_done_q, frame_done_d;

    logic accept_s;
    logic last_s;
    logic rdreq_s;

    // Handshake decode and read-issue qualification (one read in flight at most)
    always_comb begin
        accept_s = bit_valid_q & bit_ready;
        last_s   = accept_s & (idx_q == LAST_IDX);
        rdreq_s  = ~reset & enable & ~fifo_empty & ~pend_q &
                   ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & ~hold_valid_q));
        pend_d   = rdreq_s;
    end

    // Next-state logic for the shift/hold datapath, frame counter and FSM
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        bit_valid_d  = bit_valid_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rdreq_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (pend_q) begin
                    shift_d     = fifo_q;
                    idx_d       = {IDX_W{1'b0}};
                    bit_valid_d = 1'b1;
                    state_d     = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    idx_d = {IDX_W{1'b0}};
                    if (cnt_q == LAST_CNT) begin
                        cnt_d        = {CNT_W{1'b0}};
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Held byte wins the shift load; a word landing now refills hold.
                    if (hold_valid_q) begin
                        shift_d = hold_q;
                        if (pend_q) begin
                            hold_d       = fifo_q;
                            hold_valid_d = 1'b1;
                        end else begin
                            hold_valid_d = 1'b0;
                        end
                    end else if (pend_q) begin
                        shift_d = fifo_q;
                    end else begin
                        bit_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    if (accept_s) begin
                        shift_d = MSB_FIRST ? (shift_q << 1'b1) : (shift_q >> 1'b1);
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        shift_d = shift_q;
                    end
                    if (pend_q) begin
                        hold_d       = fifo_q;
                        hold_valid_d = 1'b1;
                    end else begin
                        hold_valid_d = hold_valid_q;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                bit_valid_d  = 1'b0;
                hold_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset drops any partial or held byte without replay
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= {DATA_W{1'b0}};
            hold_q       <= {DATA_W{1'b0}};
            hold_valid_q <= 1'b0;
            idx_q        <= {IDX_W{1'b0}};
            pend_q       <= 1'b0;
            bit_valid_q  <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            bit_valid_q  <= bit_valid_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo_rdreq = rdreq_s;
    assign bit_out    = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
    assign bit_valid  = bit_valid_q;
    assign byte_count = cnt_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE) | hold_valid_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Scoreboard bench: a FIFO model feeds the serializer, expected bits are queued
// per popped byte and a negedge monitor checks every transfer and frame count.
module tb_fifo_drain_serializer;

    localparam int DW = 8;
    localparam int FB = 4;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset, enable, fifo_empty, fifo_rdreq;
    logic          bit_out, bit_valid, bit_ready, frame_done, busy;
    logic [DW-1:0] fifo_q;
    logic [CW-1:0] byte_count;

    logic          l_en, l_empty, l_rdreq, l_out, l_valid, l_ready, l_fd, l_busy;
    logic [DW-1:0] l_q;
    logic [CW-1:0] l_cnt;

    fifo_drain_serializer #(.DATA_W(DW), .FRAME_BYTES(FB), .CNT_W(CW), .MSB_FIRST(1'b1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .byte_count(byte_count), .frame_done(frame_done), .busy(busy)
    );

    fifo_drain_serializer #(.DATA_W(DW), .FRAME_BYTES(FB), .CNT_W(CW), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .enable(l_en), .fifo_empty(l_empty),
        .fifo_q(l_q), .fifo_rdreq(l_rdreq), .bit_out(l_out), .bit_valid(l_valid),
        .bit_ready(l_ready), .byte_count(l_cnt), .frame_done(l_fd), .busy(l_busy)
    );

    always #5 clock = ~clock;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         popped = 0;
    int         acc_total = 0;
    int         fd_cnt = 0;
    bit         exp_q[$];
    logic [7:0] fifo_mem[$];
    bit         force_empty = 1'b0;
    bit         rd_seen = 1'b0;
    bit         prev_acc = 1'b0;
    bit         stalled = 1'b0;
    bit         stall_bit = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Transmission order of a byte: k-th bit on the wire.
    function automatic bit model_bit(input logic [7:0] b, input int k, input bit msb);
        int pos;
        pos = msb ? (7 - k) : k;
        return bit'((b >> pos) & 8'd1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_bits(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (acc_total >= n) return;
            step();
        end
        chk("wait_bits_timeout", acc_total, n);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        @(negedge clock);
        step();
        reset = 1'b0;
    endtask

    // FIFO model: answers each read request with the next byte one cycle later
    initial begin
        logic [7:0] b;
        fifo_empty = 1'b1;
        fifo_q     = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                popped = 0;
            end else if (rd_seen && fifo_mem.size() > 0) begin
                b = fifo_mem.pop_front();
                fifo_q = b;
                popped++;
                for (int k = 0; k < 8; k++) exp_q.push_back(model_bit(b, k, 1'b1));
            end
            fifo_empty = force_empty || (fifo_mem.size() == 0);
        end
    end

    // Monitor: read rules, stall stability, bit scoreboard, byte/frame counters
    initial begin
        bit e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                acc_total = 0;
                prev_acc  = 1'b0;
                stalled   = 1'b0;
                rd_seen   = 1'b0;
            end else begin
                if (fifo_empty) chk("rdreq_while_empty", int'(fifo_rdreq), 0);
                if (!enable) chk("rdreq_while_disabled", int'(fifo_rdreq), 0);
                if (fifo_rdreq) chk("rdreq_inflight", int'((popped - acc_total / 8) <= 1), 1);
                if (stalled) begin
                    chk("stall_valid", int'(bit_valid), 1);
                    chk("stall_bit", int'(bit_out), int'(stall_bit));
                end
                chk("byte_count", int'(byte_count), (acc_total / 8) % FB);
                chk("frame_done", int'(frame_done),
                    int'(prev_acc && acc_total > 0 && (acc_total % (8 * FB)) == 0));
                if (frame_done) fd_cnt++;
                prev_acc = bit_valid && bit_ready;
                if (bit_valid && bit_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bit_out", int'(bit_out), int'(e));
                    end
                    acc_total++;
                end
                stalled   = bit_valid && !bit_ready;
                stall_bit = bit_out;
                rd_seen   = fifo_rdreq;
            end
        end
    end

    initial begin
        int c0, base, fd0, pbase, k;
        bit found;
        reset = 1'b1; enable = 1'b0; bit_ready = 1'b0;
        l_en = 1'b0; l_empty = 1'b0; l_q = 8'h01; l_ready = 1'b1;
        #12;
        chk("reset_outputs", int'({fifo_rdreq, bit_out, bit_valid, byte_count, frame_done, busy}), 0);
        step();
        reset = 1'b0;

        // Single byte, first-bit latency
        fifo_mem.push_back(8'hA5);
        enable = 1'b1; bit_ready = 1'b1;
        found = 1'b0; c0 = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (fifo_rdreq) begin found = 1'b1; c0 = cyc; end
        end
        chk("first_rdreq_seen", int'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (bit_valid) found = 1'b1;
        end
        chk("first_valid_latency", cyc - c0, 2);
        wait_bits(8, 50);
        repeat (3) step();
        chk("single_valid_after", int'(bit_valid), 0);
        chk("single_byte_count", int'(byte_count), 1);
        chk("single_busy", int'(busy), 0);

        // Streaming one frame with no bubble
        do_reset();
        fd0 = fd_cnt;
        fifo_mem.push_back(8'h0F); fifo_mem.push_back(8'hF0);
        fifo_mem.push_back(8'h3C); fifo_mem.push_back(8'hC3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (bit_valid) found = 1'b1;
        end
        chk("stream_start", int'(found), 1);
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            chk("stream_gap", int'(bit_valid), 1);
        end
        wait_bits(32, 20);
        repeat (3) step();
        chk("stream_frame_pulses", fd_cnt - fd0, 1);
        chk("stream_byte_count", int'(byte_count), 0);

        // Backpressure with ready pattern 1,0,0,1
        base = acc_total;
        repeat (3) fifo_mem.push_back(8'h81);
        for (int i = 0; i < 300 && acc_total < base + 24; i++) begin
            bit_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        bit_ready = 1'b1;
        chk("backpressure_bits", acc_total - base, 24);

        // FIFO empty, then enable dropped with one byte shifting and one held
        repeat (4) step();
        force_empty = 1'b1;
        fifo_mem.push_back(8'h55); fifo_mem.push_back(8'hAA); fifo_mem.push_back(8'h77);
        repeat (20) step();
        chk("empty_no_reads", int'(busy), 0);
        force_empty = 1'b0;
        pbase = popped; base = acc_total;
        for (int i = 0; i < 30 && popped < pbase + 2; i++) step();
        enable = 1'b0;
        chk("enable_prefetched", popped - pbase, 2);
        wait_bits(base + 16, 60);
        repeat (3) step();
        chk("drain_busy", int'(busy), 0);
        chk("drain_valid", int'(bit_valid), 0);
        chk("drain_fifo_left", fifo_mem.size(), 1);
        fifo_mem.delete();
        repeat (2) step();
        enable = 1'b1;

        // Reset after three bits of 0xFF; next byte restarts cleanly
        fifo_mem.push_back(8'hFF);
        base = acc_total;
        wait_bits(base + 3, 30);
        #1 reset = 1'b1;
        #1 chk("async_reset_outputs",
               int'({fifo_rdreq, bit_out, bit_valid, byte_count, frame_done, busy}), 0);
        @(negedge clock);
        step();
        reset = 1'b0;
        fifo_mem.push_back(8'h12);
        wait_bits(8, 40);
        repeat (3) step();
        chk("post_reset_byte_count", int'(byte_count), 1);
        chk("post_reset_bits", acc_total, 8);

        // LSB-first instance with byte 0x01
        l_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (l_rdreq) found = 1'b1;
        end
        @(posedge clock);
        #1 l_en = 1'b0;
        chk("lsb_rdreq_seen", int'(found), 1);
        k = 0;
        for (int i = 0; i < 40 && k < 8; i++) begin
            @(negedge clock);
            if (l_valid) begin
                chk("lsb_bit", int'(l_out), int'(model_bit(8'h01, k, 1'b0)));
                k++;
            end
        end
        chk("lsb_bit_count", k, 8);

        // Randomized traffic, then drain
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0 && fifo_mem.size() < 6) fifo_mem.push_back(8'($urandom));
            force_empty = ($urandom_range(9) == 0);
            enable      = ($urandom_range(9) != 0);
            bit_ready   = ($urandom_range(9) < 7);
            step();
        end
        force_empty = 1'b0; enable = 1'b1; bit_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (fifo_mem.size() == 0 && !busy && exp_q.size() == 0) found = 1'b1;
        end
        chk("random_drain", int'(found), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Reader side of the encoder output FIFO: pops bytes with rdreq/empty and serializes them one bit per accepted transfer over a valid/ready handshake.
- A one-byte holding register prefetches the next byte, so back-to-back bytes stream with no bubble.
- Groups bytes into fixed-length frames and reports frame boundaries for the downstream framer.

Parameters:
- DATA_W, 8, FIFO word width; bits per byte.
- FRAME_BYTES, 4, bytes per frame; must be ≥1.
- CNT_W, 8, width of byte_count; must hold FRAME_BYTES-1.
- MSB_FIRST, 1, 1 = bit DATA_W-1 goes out first; 0 = bit 0 goes out first.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  permits new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_q  in  DATA_W  FIFO read data; valid the cycle after fifo_rdreq.
- fifo_rdreq  out  1  FIFO pop request; one-cycle pulse.
- bit_out  out  1  serial data bit.
- bit_valid  out  1  bit_out holds a valid bit.
- bit_ready  in  1  downstream accepts bit_out this cycle.
- byte_count  out  CNT_W  bytes fully sent in the current frame.
- frame_done  out  1  one-cycle pulse on the last bit of a frame.
- busy  out  1  shift or hold register occupied, or a read is outstanding.

Behaviour:
- Reset values: fifo_rdreq=0, bit_out=0, bit_valid=0, byte_count=0, frame_done=0, busy=0. Shift register, hold register, hold_valid, bit index and state all clear.
- A reset mid-byte discards the partially sent byte and the held byte; nothing is replayed.
- States:
  - IDLE: shift register empty.
  - WAIT: read issued; data arrives next cycle.
  - SHIFT: shift register is presenting bits.
- fifo_rdreq is asserted only when all of these hold:
  - enable=1 and fifo_empty=0;
  - no read is outstanding (at most one in flight);
  - the destination is free: IDLE, or SHIFT with hold_valid=0.
- fifo_rdreq is never asserted while fifo_empty=1.
- IDLE → WAIT on a rdreq. WAIT → SHIFT: fifo_q is loaded into the shift register; bit_valid=1 the cycle after the load. Latency from rdreq to first bit_valid is 2 cycles.
- In SHIFT, a rdreq loads fifo_q into the hold register next cycle and sets hold_valid.
- Transfer: a bit is accepted when bit_valid && bit_ready. On acceptance, advance to the next bit in MSB_FIRST order.
- bit_out and bit_valid must stay stable while bit_valid && !bit_ready.
- When the last bit (index DATA_W-1 of the byte) is accepted:
  - hold_valid=1: copy hold into the shift register in the same cycle and clear hold_valid; bit_valid stays 1, so there is no bubble.
  - hold_valid=0 and a read is arriving this cycle: load fifo_q directly, stay in SHIFT.
  - Otherwise: bit_valid→0, go to IDLE.
- byte_count increments when the last bit of a byte is accepted. At FRAME_BYTES-1 it wraps to 0 and frame_done pulses in the next cycle, registered.
- enable=0 blocks new reads only. The current byte and any held byte still drain. enable has no effect on bits already loaded.
- A simultaneous prefetch capture and last-bit acceptance is legal. The hold path has priority for the shift load, and the captured word goes into hold, so no data is lost.
- busy = (state≠IDLE) | hold_valid.

Test Plan:
- Single byte: FIFO holds 0xA5, MSB_FIRST=1, bit_ready=1 → rdreq at cycle 0, first bit_valid at cycle 2. bit_out sequence 1,0,1,0,0,1,0,1. byte_count 0→1. bit_valid=0 afterwards.
- Streaming: FIFO holds 0x0F, 0xF0, 0x3C, 0xC3, bit_ready=1 → 32 consecutive valid bits with no gap. frame_done pulses exactly once, one cycle after the 32nd bit. byte_count returns to 0.
- Backpressure: bit_ready toggles 1,0,0,1 repeatedly on 0x81 → bit_out is stable while stalled. Output is 1,0,0,0,0,0,0,1. The second rdreq is not issued while hold_valid=1.
- Empty/enable: fifo_empty=1 for 20 cycles, then enable=0 while 0x55 is in the shift register and 0xAA is held → fifo_rdreq never asserts. Both bytes drain fully, then busy=0 and state is IDLE.
- Reset mid-byte: assert reset after 3 bits of 0xFF → all outputs 0 immediately, without waiting for a clock edge. After release, the next FIFO byte 0x12 is sent from bit 7 and byte_count restarts at 0.
- LSB order: MSB_FIRST=0, byte 0x01 → first accepted bit is 1, the remaining 7 bits are 0.
